// File: rtl/kernel_buffer.sv
// kernel_buffer: captures a square convolution kernel streamed in byte by byte
// (row-major) and presents it as a flat bus plus a registered single-tap read port.
module kernel_buffer #(
  parameter int KERNEL_DIM = 7,
  parameter int DATA_WIDTH = 8,
  localparam int KERNEL_SIZE = KERNEL_DIM * KERNEL_DIM
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_enable,
  input  logic                             byte_valid,
  input  logic [DATA_WIDTH-1:0]            byte_in,
  input  logic                             clear_kernel,
  input  logic [5:0]                       tap_addr,
  output logic [DATA_WIDTH-1:0]            tap_data,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] kernel_flat,
  output logic                             kernel_loaded,
  output logic [5:0]                       load_count,
  output logic                             byte_dropped
);

  localparam logic [5:0] LAST_TAP = 6'(KERNEL_SIZE - 1);
  localparam logic [5:0] NUM_TAPS = 6'(KERNEL_SIZE);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [5:0]            count_reg, count_next;
  logic                  dropped_reg, dropped_next;
  logic                  write_en;
  logic                  accept;
  logic [DATA_WIDTH-1:0] tap_reg [KERNEL_SIZE];

  // A byte only counts when the master is in its kernel-load phase.
  assign accept = byte_valid & load_enable;

  // State, tap counter and drop pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= EMPTY;
      count_reg   <= '0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      dropped_reg <= dropped_next;
    end
  end

  // Next-state logic; clear has priority over any byte arriving in the same cycle.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    dropped_next = 1'b0;
    write_en     = 1'b0;
    if (clear_kernel) begin
      state_next = EMPTY;
      count_next = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            write_en   = 1'b1;
            count_next = 6'd1;
            state_next = (LAST_TAP == 6'd0) ? LOADED : LOADING;
          end
        end
        LOADING: begin
          if (accept) begin
            write_en   = 1'b1;
            count_next = count_reg + 6'd1;
            if (count_reg == LAST_TAP) begin
              state_next = LOADED;
            end
          end
        end
        LOADED: begin
          // Kernel is full: excess bytes are discarded and flagged.
          if (accept) begin
            dropped_next = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          count_next = '0;
        end
      endcase
    end
  end

  // One register per tap so the whole kernel is visible on the flat bus.
  generate
    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_tap
      // Tap gi is written when the load pointer reaches it; clear wipes it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tap_reg[gi] <= '0;
        end else if (clear_kernel) begin
          tap_reg[gi] <= '0;
        end else if (write_en && (count_reg == 6'(gi))) begin
          tap_reg[gi] <= byte_in;
        end
      end
      assign kernel_flat[gi*DATA_WIDTH +: DATA_WIDTH] = tap_reg[gi];
    end
  endgenerate

  // Registered read port; samples the old tap value if it is written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_data <= '0;
    end else if (tap_addr < NUM_TAPS) begin
      tap_data <= tap_reg[tap_addr];
    end else begin
      tap_data <= '0;
    end
  end

  assign kernel_loaded = (state_reg == LOADED);
  assign load_count    = count_reg;
  assign byte_dropped  = dropped_reg;

endmodule

// File: tb/tb_kernel_buffer.sv
// tb_kernel_buffer: scoreboard bench; expected outputs are pushed when a cycle's
// stimulus is driven and popped/compared one edge later.
module tb_kernel_buffer;

  localparam int KS = 49;
  localparam int FW = KS * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_enable;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          clear_kernel;
  logic [5:0]    tap_addr;
  logic [7:0]    tap_data;
  logic [FW-1:0] kernel_flat;
  logic          kernel_loaded;
  logic [5:0]    load_count;
  logic          byte_dropped;

  kernel_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (load_enable),
    .byte_valid   (byte_valid),
    .byte_in      (byte_in),
    .clear_kernel (clear_kernel),
    .tap_addr     (tap_addr),
    .tap_data     (tap_data),
    .kernel_flat  (kernel_flat),
    .kernel_loaded(kernel_loaded),
    .load_count   (load_count),
    .byte_dropped (byte_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    count;
    logic          loaded;
    logic          dropped;
    logic [7:0]    tdata;
    logic [FW-1:0] flat;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int         m_count;
  logic [7:0] m_taps [KS];

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < KS; i++) f[i*8 +: 8] = m_taps[i];
    return f;
  endfunction

  task automatic model_reset();
    m_count = 0;
    for (int i = 0; i < KS; i++) m_taps[i] = 8'h00;
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), predict, then compare.
  task automatic step(input bit v, input bit en, input logic [7:0] b, input bit clr,
                      input logic [5:0] addr, input string tag);
    exp_t e;
    byte_valid   = v;
    load_enable  = en;
    byte_in      = b;
    clear_kernel = clr;
    tap_addr     = addr;
    e.tdata   = (addr < KS) ? m_taps[addr] : 8'h00;
    e.dropped = 1'b0;
    if (clr) begin
      model_reset();
    end else if (v && en) begin
      if (m_count < KS) begin
        m_taps[m_count] = b;
        m_count++;
      end else begin
        e.dropped = 1'b1;
      end
    end
    e.count  = 6'(m_count);
    e.loaded = (m_count == KS);
    e.flat   = model_flat();
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_count"},   load_count,    e.count);
      check({tag, "_loaded"},  kernel_loaded, e.loaded);
      check({tag, "_dropped"}, byte_dropped,  e.dropped);
      check({tag, "_tdata"},   tap_data,      e.tdata);
      check({tag, "_flat"},    kernel_flat,   e.flat);
      $display("txn %s: count=%0d loaded=%0b dropped=%0b tap_data=%0h",
               tag, load_count, kernel_loaded, byte_dropped, tap_data);
    end
  endtask

  // Feed n accepted bytes starting at value first; read address tracks the tap being written.
  task automatic load_bytes(input int n, input int first, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1, 1, 8'(first + i), 0, 6'(m_count), tag);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"},   load_count,    0);
    check({tag, "_loaded"},  kernel_loaded, 0);
    check({tag, "_dropped"}, byte_dropped,  0);
    check({tag, "_tdata"},   tap_data,      0);
    check({tag, "_flat"},    kernel_flat,   0);
    $display("txn %s: count=%0d loaded=%0b tap_data=%0h", tag, load_count, kernel_loaded, tap_data);
  endtask

  initial begin
    rst          = 1'b1;
    load_enable  = 1'b0;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    clear_kernel = 1'b0;
    tap_addr     = 6'd0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full load 1..49; kernel_loaded must rise with the 49th byte.
    load_bytes(KS, 1, "load1");
    check("flat_tap0",  kernel_flat[7:0],     1);
    check("flat_tap48", kernel_flat[391:384], 49);

    // Excess bytes are dropped and flagged, taps untouched.
    for (int i = 0; i < 3; i++) step(1, 1, 8'hFF, 0, 6'd5, "excess");
    step(0, 0, 8'h00, 0, 6'd0, "idle");

    // Read port checks, including out-of-range address.
    step(0, 0, 8'h00, 0, 6'd0,  "rd0");
    step(0, 0, 8'h00, 0, 6'd48, "rd48");
    step(0, 0, 8'h00, 0, 6'd55, "rd55");
    step(0, 0, 8'h00, 0, 6'd63, "rd63");

    // Clear coincident with an accept: clear wins, no drop pulse.
    step(1, 1, 8'hAA, 1, 6'd0, "clr_acc");

    // Partial load, then byte_valid without load_enable is ignored.
    load_bytes(10, 100, "load2");
    for (int i = 0; i < 3; i++) step(1, 0, 8'hEE, 0, 6'd3, "noen");
    step(0, 1, 8'hDD, 0, 6'd3, "novalid");
    load_bytes(KS - 10, 110, "load2b");
    step(1, 1, 8'h11, 0, 6'd48, "excess2");

    // Clear alone, then load 20 and hit async reset mid-cycle.
    step(0, 0, 8'h00, 1, 6'd0, "clr");
    load_bytes(20, 1, "load3");
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reload after reset starts at tap 0, then read back the corners.
    load_bytes(KS, 1, "load4");
    check("flat4_tap0",  kernel_flat[7:0],     1);
    check("flat4_tap48", kernel_flat[391:384], 49);
    step(0, 0, 8'h00, 0, 6'd0,  "rd4_0");
    step(0, 0, 8'h00, 0, 6'd48, "rd4_48");
    step(0, 0, 8'h00, 0, 6'd55, "rd4_55");

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
